// File: rtl/char_blender_pipe_pkg.sv
// Shared definitions for the character blender: the RGB444 color type,
// channel slice positions, attribute bit positions and the alpha ceiling.
package char_pkg;

  typedef logic [11:0] rgb444_t;

  // Each color channel is a 4-bit slice; red is the top nibble.
  localparam int CH_W     = 4;
  localparam int CH_R_LSB = 8;
  localparam int CH_G_LSB = 4;
  localparam int CH_B_LSB = 0;

  // Attribute nibble is {cursor, blink, inverse, underline}, MSB first.
  localparam int ATTR_CURSOR    = 3;
  localparam int ATTR_BLINK     = 2;
  localparam int ATTR_INVERSE   = 1;
  localparam int ATTR_UNDERLINE = 0;

  // Largest glyph alpha code for a given precision.
  function automatic int amax(input int alpha_bits);
    return (1 << alpha_bits) - 1;
  endfunction

endpackage

// File: rtl/char_blender_pipe_if.sv
// Pixel request / pixel result bundle. The master drives requests and frame
// pulses; the slave (the blender) returns blended pixels.
interface char_blender_pipe_if #(
  parameter int CHAR_W = 8,
  parameter int CHAR_H = 8
);
  import char_pkg::*;

  localparam int COL_W = $clog2(CHAR_W);
  localparam int ROW_W = $clog2(CHAR_H);

  logic             i_valid;
  logic [7:0]       i_char;
  logic [ROW_W-1:0] i_row;
  logic [COL_W-1:0] i_column;
  rgb444_t          i_fg_color;
  rgb444_t          i_bg_color;
  logic [3:0]       i_attr;
  logic             i_frame_start;
  logic             o_valid;
  rgb444_t          o_color;

  modport master (
    output i_valid, i_char, i_row, i_column, i_fg_color, i_bg_color,
           i_attr, i_frame_start,
    input  o_valid, o_color
  );

  modport slave (
    input  i_valid, i_char, i_row, i_column, i_fg_color, i_bg_color,
           i_attr, i_frame_start,
    output o_valid, o_color
  );

endinterface

// File: rtl/char_blender_pipe_char_gen_param.sv
// Glyph alpha ROM with a registered output. The glyph set is procedural:
//   code 8'h00        -> blank (alpha 0)
//   code 8'hFF        -> solid (alpha AMAX)
//   codes 8'h80..8'hFE -> uniform shade, alpha = low ALPHA_BITS of the code
//   codes 8'h01..8'h7F -> diagonal ramp, alpha = (code + row + column) mod 2^ALPHA_BITS
module char_gen_param
  import char_pkg::*;
#(
  parameter int CHAR_W     = 8,
  parameter int CHAR_H     = 8,
  parameter int ALPHA_BITS = 3
) (
  input  logic                        i_clk,
  input  logic [7:0]                  i_char,
  input  logic [$clog2(CHAR_H)-1:0]   i_row,
  input  logic [$clog2(CHAR_W)-1:0]   i_column,
  output logic [ALPHA_BITS-1:0]       o_alpha
);

  localparam logic [ALPHA_BITS-1:0] AMAX_V = ALPHA_BITS'(amax(ALPHA_BITS));

  logic [ALPHA_BITS-1:0] alpha_next;
  logic [ALPHA_BITS-1:0] ramp;

  // Decode the glyph alpha for the addressed cell pixel.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    alpha_next = '0;
    ramp       = ALPHA_BITS'(i_char) + ALPHA_BITS'(i_row) + ALPHA_BITS'(i_column);
    if (i_char == 8'hFF)       alpha_next = AMAX_V;
    else if (i_char[7])        alpha_next = i_char[ALPHA_BITS-1:0];
    else if (i_char != 8'h00)  alpha_next = ramp;
  end

  // Register the looked-up alpha.
  always_ff @(posedge i_clk) begin
    // NOTE: pure data registers carry no reset; only the valid bits that qualify them do. Sequential state uses <= so every flop samples pre-edge values.
    o_alpha <= alpha_next;
  end

endmodule

// File: rtl/char_blender_pipe.sv
// Text-mode pixel blender: glyph lookup, attribute modifiers, alpha blend.
// Four register ranks (accept, glyph, modifiers, blend) give a fixed
// three-edge latency from the accepting edge to o_valid.
module char_blender_pipe
  import char_pkg::*;
#(
  parameter int CHAR_W       = 8,
  parameter int CHAR_H       = 8,
  parameter int ALPHA_BITS   = 3,
  parameter int BLINK_FRAMES = 30
) (
  input logic               i_clk,
  input logic               i_rst_n,
  char_blender_pipe_if.slave bus
);

  localparam int ROW_W = $clog2(CHAR_H);
  localparam int COL_W = $clog2(CHAR_W);
  localparam int ACC_W = ALPHA_BITS + CH_W + 1;
  localparam logic [ALPHA_BITS-1:0] AMAX_V     = ALPHA_BITS'(amax(ALPHA_BITS));
  localparam logic [ALPHA_BITS:0]   W_FULL     = (ALPHA_BITS+1)'(1) << ALPHA_BITS;
  localparam logic [ROW_W-1:0]      LAST_ROW   = ROW_W'(CHAR_H - 1);
  localparam logic [7:0]            BLINK_LAST = 8'(BLINK_FRAMES - 1);

  // One channel of (fg*w + bg*(2^ALPHA_BITS - w)) >> ALPHA_BITS, truncated.
  function automatic logic [CH_W-1:0] blend_ch(input logic [CH_W-1:0] fg,
                                               input logic [CH_W-1:0] bg,
                                               input logic [ALPHA_BITS:0] w);
    logic [ACC_W-1:0] acc;
    acc = ACC_W'(fg) * ACC_W'(w) + ACC_W'(bg) * ACC_W'(W_FULL - w);
    return CH_W'(acc >> ALPHA_BITS);
  endfunction

  logic [7:0]            frame_cnt;
  logic                  phase;

  logic                  s0_valid, s0_phase;
  logic [7:0]            s0_char;
  logic [ROW_W-1:0]      s0_row;
  logic [COL_W-1:0]      s0_col;
  rgb444_t               s0_fg, s0_bg;
  logic [3:0]            s0_attr;

  logic                  s1_valid, s1_phase, s1_last_row;
  logic [ALPHA_BITS-1:0] s1_alpha;
  rgb444_t               s1_fg, s1_bg;
  logic [3:0]            s1_attr;

  logic [ALPHA_BITS-1:0] alpha_mod;
  logic                  swap;

  logic                  s2_valid;
  logic [ALPHA_BITS-1:0] s2_alpha;
  rgb444_t               s2_fg, s2_bg;

  logic [ALPHA_BITS:0]   w;
  rgb444_t               blended;

  // Blink timebase: count frame pulses, toggle phase every BLINK_FRAMES.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_cnt <= '0;
      phase     <= 1'b1;
    end else if (bus.i_frame_start) begin
      if (frame_cnt == BLINK_LAST) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // Valid chain and output pixel; reset drops everything in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s0_valid    <= 1'b0;
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      bus.o_valid <= 1'b0;
      bus.o_color <= '0;
    end else begin
      s0_valid    <= bus.i_valid;
      s1_valid    <= s0_valid;
      s2_valid    <= s1_valid;
      bus.o_valid <= s2_valid;
      if (s2_valid) bus.o_color <= blended;
    end
  end

  // Data side of the pipeline; the phase is captured with the pixel so a
  // coincident frame pulse only affects later pixels.
  always_ff @(posedge i_clk) begin
    s0_char     <= bus.i_char;
    s0_row      <= bus.i_row;
    s0_col      <= bus.i_column;
    s0_fg       <= bus.i_fg_color;
    s0_bg       <= bus.i_bg_color;
    s0_attr     <= bus.i_attr;
    s0_phase    <= phase;
    s1_fg       <= s0_fg;
    s1_bg       <= s0_bg;
    s1_attr     <= s0_attr;
    s1_phase    <= s0_phase;
    s1_last_row <= (s0_row == LAST_ROW);
    s2_alpha    <= alpha_mod;
    s2_fg       <= swap ? s1_bg : s1_fg;
    s2_bg       <= swap ? s1_fg : s1_bg;
  end

  char_gen_param #(
    .CHAR_W     (CHAR_W),
    .CHAR_H     (CHAR_H),
    .ALPHA_BITS (ALPHA_BITS)
  ) u_char_gen (
    .i_clk    (i_clk),
    .i_char   (s0_char),
    .i_row    (s0_row),
    .i_column (s0_col),
    .o_alpha  (s1_alpha)
  );

  // Attribute modifiers, applied in order: underline, blink, then swap.
  always_comb begin
    alpha_mod = s1_alpha;
    if (s1_attr[ATTR_UNDERLINE] && s1_last_row) alpha_mod = AMAX_V;
    if (s1_attr[ATTR_BLINK] && !s1_phase)       alpha_mod = '0;
    swap = s1_attr[ATTR_INVERSE] ^ (s1_attr[ATTR_CURSOR] & s1_phase);
  end

  // Blend weight saturates to 2^ALPHA_BITS so AMAX gives exactly fg.
  always_comb begin
    w = (ALPHA_BITS+1)'(s2_alpha) + (ALPHA_BITS+1)'(s2_alpha == AMAX_V);
    blended = '0;
    blended[CH_R_LSB +: CH_W] = blend_ch(s2_fg[CH_R_LSB +: CH_W], s2_bg[CH_R_LSB +: CH_W], w);
    blended[CH_G_LSB +: CH_W] = blend_ch(s2_fg[CH_G_LSB +: CH_W], s2_bg[CH_G_LSB +: CH_W], w);
    blended[CH_B_LSB +: CH_W] = blend_ch(s2_fg[CH_B_LSB +: CH_W], s2_bg[CH_B_LSB +: CH_W], w);
  end

endmodule

// File: tb/tb_char_blender_pipe.sv
// Bench for char_blender_pipe in a 16x16-cell, 3-bit alpha, 2-frame blink
// build: directed literal pixels plus a randomized run against a queue-based
// reference model that is compared every cycle.
module tb_char_blender_pipe;
  import char_pkg::*;

  localparam int CW   = 16;
  localparam int CH   = 16;
  localparam int AB   = 3;
  localparam int BF   = 2;
  localparam int AMAX = (1 << AB) - 1;

  typedef struct {
    int      due;
    rgb444_t color;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  char_blender_pipe_if #(.CHAR_W(CW), .CHAR_H(CH)) bus ();

  char_blender_pipe #(
    .CHAR_W(CW), .CHAR_H(CH), .ALPHA_BITS(AB), .BLINK_FRAMES(BF)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference pixel computed straight from the glyph and attribute rules.
  function automatic rgb444_t model_pixel(input logic [7:0] ch, input int row, input int col,
                                          input rgb444_t fg, input rgb444_t bg,
                                          input logic [3:0] attr, input bit ph);
    int a, w;
    rgb444_t f, b, r;
    if (ch == 8'h00)      a = 0;
    else if (ch == 8'hFF) a = AMAX;
    else if (ch >= 8'h80) a = int'(ch) % (AMAX + 1);
    else                  a = (int'(ch) + row + col) % (AMAX + 1);
    if (attr[0] && row == CH - 1) a = AMAX;
    if (attr[2] && !ph)           a = 0;
    f = fg;
    b = bg;
    if (attr[1] ^ (attr[3] && ph)) begin
      f = bg;
      b = fg;
    end
    w = (a == AMAX) ? AMAX + 1 : a;
    r = '0;
    for (int c = 0; c < 3; c++)
      r[c*4 +: 4] = 4'((int'(f[c*4 +: 4]) * w + int'(b[c*4 +: 4]) * (AMAX + 1 - w)) / (AMAX + 1));
    return r;
  endfunction

  // Model: tracks accepted pixels, due edges, blink timebase and held color.
  exp_t    q[$];
  int      cyc = 0;
  bit      exp_valid = 1'b0;
  rgb444_t exp_color = '0;
  int      m_cnt = 0;
  bit      m_phase = 1'b1;

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      exp_valid = 1'b0;
      exp_color = '0;
      m_cnt     = 0;
      m_phase   = 1'b1;
    end else begin
      exp_valid = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_valid = 1'b1;
        exp_color = q[0].color;
        void'(q.pop_front());
      end
      if (bus.i_valid)
        q.push_back('{cyc + 3, model_pixel(bus.i_char, int'(bus.i_row), int'(bus.i_column),
                                           bus.i_fg_color, bus.i_bg_color, bus.i_attr, m_phase)});
      if (bus.i_frame_start) begin
        if (m_cnt == BF - 1) begin
          m_cnt   = 0;
          m_phase = !m_phase;
        end else begin
          m_cnt++;
        end
      end
    end
    cyc++;
  end

  // Compare process: outputs against the model on every falling edge.
  initial forever begin
    @(negedge clk);
    check("cmp_o_valid", bus.o_valid, exp_valid);
    check("cmp_o_color", bus.o_color, exp_color);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_valid       = 1'b0;
    bus.i_frame_start = 1'b0;
  endtask

  task automatic frame_pulse();
    bus.i_frame_start = 1'b1;
    step();
    bus.i_frame_start = 1'b0;
  endtask

  task automatic drive_random_pixel(input bit valid);
    bus.i_valid = valid;
    case ($urandom_range(0, 3))
      0:       bus.i_char = 8'h00;
      1:       bus.i_char = 8'hFF;
      2:       bus.i_char = 8'h80 | 8'($urandom_range(0, 127));
      default: bus.i_char = 8'($urandom_range(0, 127));
    endcase
    bus.i_row      = 4'($urandom_range(0, CH - 1));
    bus.i_column   = 4'($urandom_range(0, CW - 1));
    bus.i_fg_color = 12'($urandom);
    bus.i_bg_color = 12'($urandom);
    bus.i_attr     = 4'($urandom);
  endtask

  // One isolated pixel with a hand-computed expected color and exact latency.
  task automatic pixel_lit(input string name, input logic [7:0] ch, input logic [3:0] row,
                           input logic [3:0] col, input rgb444_t fg, input rgb444_t bg,
                           input logic [3:0] attr, input rgb444_t exp);
    bus.i_valid    = 1'b1;
    bus.i_char     = ch;
    bus.i_row      = row;
    bus.i_column   = col;
    bus.i_fg_color = fg;
    bus.i_bg_color = bg;
    bus.i_attr     = attr;
    step();
    bus.i_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({name, "_early"}, bus.o_valid, 1'b0);
    @(negedge clk);
    check({name, "_valid"}, bus.o_valid, 1'b1);
    check({name, "_color"}, bus.o_color, exp);
    #1;
  endtask

  initial begin
    int ghosts;
    idle();
    bus.i_char = '0; bus.i_row = '0; bus.i_column = '0;
    bus.i_fg_color = '0; bus.i_bg_color = '0; bus.i_attr = '0;
    repeat (3) step();
    check("rst_o_valid", bus.o_valid, 1'b0);
    check("rst_o_color", bus.o_color, 12'h000);
    rst_n = 1'b1;

    pixel_lit("solid_fg",    8'hFF, 4'd0,  4'd0,  12'hF00, 12'h00F, 4'b0000, 12'hF00);
    pixel_lit("alpha4",      8'h84, 4'd3,  4'd5,  12'hFFF, 12'h000, 4'b0000, 12'h777);
    pixel_lit("alpha0",      8'h00, 4'd3,  4'd5,  12'hFFF, 12'h000, 4'b0000, 12'h000);
    pixel_lit("alpha0_bg",   8'h00, 4'd7,  4'd2,  12'hFFF, 12'h5A3, 4'b0000, 12'h5A3);
    pixel_lit("alpha3_mix",  8'h83, 4'd1,  4'd1,  12'hABC, 12'h123, 4'b0000, 12'h456);
    pixel_lit("uline_last",  8'h00, 4'd15, 4'd4,  12'h0F0, 12'h321, 4'b0001, 12'h0F0);
    pixel_lit("uline_row0",  8'h00, 4'd0,  4'd4,  12'h0F0, 12'h321, 4'b0001, 12'h321);
    pixel_lit("corner_sh5",  8'h85, 4'd15, 4'd15, 12'hFFF, 12'h000, 4'b0000, 12'h999);
    pixel_lit("corner_ramp", 8'h01, 4'd15, 4'd15, 12'hABC, 12'h123, 4'b0000, 12'hABC);

    pixel_lit("blink_p0",    8'hFF, 4'd2,  4'd2,  12'hF00, 12'h00F, 4'b0100, 12'hF00);
    frame_pulse();
    pixel_lit("blink_p1",    8'hFF, 4'd2,  4'd2,  12'hF00, 12'h00F, 4'b0100, 12'hF00);
    frame_pulse();
    pixel_lit("blink_p2",    8'hFF, 4'd2,  4'd2,  12'hF00, 12'h00F, 4'b0100, 12'h00F);
    pixel_lit("curinv_ph0",  8'hFF, 4'd2,  4'd2,  12'hF00, 12'h00F, 4'b1010, 12'h00F);
    frame_pulse();
    frame_pulse();
    pixel_lit("blink_p4",    8'hFF, 4'd2,  4'd2,  12'hF00, 12'h00F, 4'b0100, 12'hF00);
    pixel_lit("curinv_ph1",  8'hFF, 4'd2,  4'd2,  12'hF00, 12'h00F, 4'b1010, 12'hF00);
    pixel_lit("cursor_ph1",  8'hFF, 4'd2,  4'd2,  12'hF00, 12'h00F, 4'b1000, 12'h00F);

    for (int i = 0; i < 2000; i++) begin
      drive_random_pixel($urandom_range(0, 9) < 7);
      bus.i_frame_start = ($urandom_range(0, 9) == 0);
      step();
    end
    idle();
    repeat (5) step();

    for (int i = 0; i < 16; i++) begin
      drive_random_pixel(1'b1);
      step();
    end
    idle();
    repeat (4) step();
    for (int i = 0; i < 2; i++) begin
      drive_random_pixel(1'b1);
      step();
    end
    rst_n = 1'b0;
    #1;
    check("midrst_o_valid", bus.o_valid, 1'b0);
    check("midrst_o_color", bus.o_color, 12'h000);
    idle();
    repeat (3) step();
    rst_n = 1'b1;
    ghosts = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.o_valid) ghosts++;
      #1;
    end
    check("midrst_no_ghost", ghosts, 0);
    check("midrst_color_held", bus.o_color, 12'h000);

    pixel_lit("post_rst", 8'hFF, 4'd0, 4'd0, 12'h0F0, 12'h00F, 4'b0000, 12'h0F0);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/char_blender_pipe.md
CHAR_BLENDER_PIPE -- requirements
Module: char_blender_pipe

Interface
REQ-001 Parameter CHAR_W, default 8: glyph cell width in pixels (8 or 16).
REQ-002 Parameter CHAR_H, default 8: glyph cell height in pixels (8 or 16).
REQ-003 Parameter ALPHA_BITS, default 3: glyph alpha precision; AMAX = 2^ALPHA_BITS-1.
REQ-004 Parameter BLINK_FRAMES, default 30: frames per blink half-period, range 1..255.
REQ-005 i_clk  in  1  sole clock; all state on rising edge.
REQ-006 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 i_valid  in  1  pixel request qualifier.
REQ-008 i_char  in  8  character code.
REQ-009 i_row  in  clog2(CHAR_H)  row within cell.
REQ-010 i_column  in  clog2(CHAR_W)  column within cell.
REQ-011 i_fg_color / i_bg_color  in  12 each  RGB444 foreground/background.
REQ-012 i_attr  in  4  {cursor, blink, inverse, underline}, MSB first.
REQ-013 i_frame_start  in  1  one-cycle pulse per video frame.
REQ-014 o_valid  out  1  output pixel qualifier.
REQ-015 o_color  out  12  blended RGB444 pixel.

Function
REQ-016 Fixed latency 3: request accepted at edge N appears with o_valid=1 after edge N+3; no backpressure, one pixel per cycle sustained.
REQ-017 Stage 1: glyph lookup in char_gen_param (registered, 1 cycle); colors, attr, row and blink phase carried alongside.
REQ-018 Stage 2 alpha modifiers, in order: underline and row==CHAR_H-1 -> alpha=AMAX; blink and phase=0 -> alpha=0; inverse XOR (cursor and phase=1) -> swap fg/bg.
REQ-019 Stage 3 blend per 4-bit channel: w = alpha + (alpha==AMAX), out = (fg*w + bg*(2^ALPHA_BITS - w)) >> ALPHA_BITS, truncated, no rounding.
REQ-020 alpha=0 -> o_color exactly bg; alpha=AMAX -> exactly fg.
REQ-021 o_valid low -> o_color holds its last value; sideband of invalid requests is don't-care and never affects o_valid.
REQ-022 Frame counter 8 bits: on i_frame_start, counter==BLINK_FRAMES-1 -> counter=0 and phase toggles; else counter+1.
REQ-023 Phase sampled with the pixel at acceptance; i_frame_start coincident with i_valid -> that pixel uses the pre-toggle phase.
REQ-024 Row/column values outside cell range are undefined input; block must not hang and o_valid timing is unaffected.

Reset
REQ-025 While i_rst_n=0: o_valid=0, o_color=12'h000, all pipeline valid bits 0, frame counter 0, phase 1.
REQ-026 Reset asserted mid-stream discards all in-flight pixels; no o_valid pulse for them after release.
REQ-027 First request accepted at first rising edge with i_rst_n=1 sampled.

Structure
REQ-028 Shared package char_pkg: RGB444 channel slice constants, attribute bit indices, AMAX function, color typedef.
REQ-029 One sub-module char_gen_param (glyph ROM, parameters CHAR_W, CHAR_H, ALPHA_BITS, 1-cycle registered alpha); blend arithmetic inline.

Verification
REQ-030 Reset then i_valid one cycle, glyph alpha=AMAX, fg=12'hF00, bg=12'h00F, attr=0 -> o_valid exactly 3 cycles later, o_color=12'hF00.
REQ-031 ALPHA_BITS=3, alpha=4, fg=12'hFFF, bg=12'h000 -> w=4, o_color=12'h777; alpha=0 -> 12'h000.
REQ-032 Underline, row=CHAR_H-1, blank glyph, fg=12'h0F0 -> 12'h0F0; same at row 0 -> bg.
REQ-033 BLINK_FRAMES=2, blink attr, solid glyph: pulses 1-2 visible fg, after 2nd pulse bg, after 4th fg again; cursor with inverse -> no swap while phase=1.
REQ-034 Back-to-back 16 valid pixels, then gap, then i_rst_n low at cycle 2 of a burst -> in-flight pixels dropped, o_valid=0, o_color=12'h000.
REQ-035 CHAR_W=16, CHAR_H=16 build: column 15/row 15 glyph corner pixel blended correctly, latency still 3.
